// File: rtl/juego_pkg.sv
// Shared game definitions: cell and game-state codes, board size, and the
// shot-selector state encoding used by selector_disparo.
package juego_pkg;

  localparam int N_TABLERO = 5;

  typedef logic [2:0] coord_t;
  typedef logic [2:0] celda_t;

  localparam celda_t CELDA_AGUA    = 3'b001;
  localparam celda_t CELDA_BARCO   = 3'b010;
  localparam celda_t CELDA_TOCADO  = 3'b011;
  localparam celda_t CELDA_FALLADO = 3'b100;

  localparam logic [2:0] EST_INICIO  = 3'b000;
  localparam logic [2:0] EST_COLOCAR = 3'b001;
  localparam logic [2:0] EST_JUGADOR = 3'b010;
  localparam logic [2:0] EST_PC      = 3'b011;
  localparam logic [2:0] EST_FIN     = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    FIRE   = 2'd2,
    WAIT   = 2'd3
  } sel_state_t;

  // Bit positions of the five buttons in the edge-detector vector.
  localparam int BTN_DER     = 0;
  localparam int BTN_IZQ     = 1;
  localparam int BTN_ABAJO   = 2;
  localparam int BTN_ARRIBA  = 3;
  localparam int BTN_DISPARO = 4;

  typedef struct packed {
    logic   hit;
    coord_t x;
    coord_t y;
  } celda_sel_t;

  function automatic logic celda_disparada(input celda_t c);
    return (c == CELDA_TOCADO) || (c == CELDA_FALLADO);
  endfunction

endpackage

// File: rtl/selector_disparo_if.sv
// Player-side shot-selection bus: game context and buttons in, cursor and
// shot strobes out. master = stimulus/UI side, slave = selector_disparo.
interface selector_disparo_if
  import juego_pkg::*;
#(
  parameter int N = N_TABLERO
);

  logic [2:0]                estado;
  logic                      turno;
  logic                      btn_arriba;
  logic                      btn_abajo;
  logic                      btn_izq;
  logic                      btn_der;
  logic                      btn_disparo;
  logic [N-1:0][N-1:0][2:0]  pc_board;   // [row y][col x]
  coord_t                    x;
  coord_t                    y;
  logic                      disparo;
  logic                      invalido;
  logic                      activo;

  modport master (
    output estado, turno, btn_arriba, btn_abajo, btn_izq, btn_der,
           btn_disparo, pc_board,
    input  x, y, disparo, invalido, activo
  );

  modport slave (
    input  estado, turno, btn_arriba, btn_abajo, btn_izq, btn_der,
           btn_disparo, pc_board,
    output x, y, disparo, invalido, activo
  );

endinterface

// File: rtl/selector_disparo_detector_flanco.sv
// detector_flanco: 1-bit synchronous rising-edge detector for a debounced
// button level; history presets to 1 so a button held through reset is no press.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic flanco
);

  logic prev;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) prev <= 1'b1;
    else        prev <= d;
  end

  assign flanco = d & ~prev;

endmodule

// File: rtl/selector_disparo.sv
// selector_disparo: button-driven cursor on the PC board and one-shot-per-turn
// shot request for jugador. Optional auto-fire on turn timeout: TURNO_TIMEOUT_EN.
module selector_disparo
  import juego_pkg::*;
#(
  parameter int N              = N_TABLERO,
  parameter int TIMEOUT_CYCLES = 750_000_000
) (
  input  logic                clk,
  input  logic                reset,
  selector_disparo_if.slave   bus
);

  localparam coord_t MAX_C = coord_t'(N - 1);

  if (N < 2 || N > 8) begin : g_n_check
    $error("selector_disparo: N must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("selector_disparo: TIMEOUT_CYCLES must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // Button edge detection
  // ---------------------------------------------------------------------------
  logic [4:0] nivel;
  logic [4:0] flanco;

  assign nivel[BTN_DER]     = bus.btn_der;
  assign nivel[BTN_IZQ]     = bus.btn_izq;
  assign nivel[BTN_ABAJO]   = bus.btn_abajo;
  assign nivel[BTN_ARRIBA]  = bus.btn_arriba;
  assign nivel[BTN_DISPARO] = bus.btn_disparo;

  for (genvar i = 0; i < 5; i++) begin : g_det
    detector_flanco u_det (
      .clk    (clk),
      .reset  (reset),
      .d      (nivel[i]),
      .flanco (flanco[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Selection FSM
  // ---------------------------------------------------------------------------
  sel_state_t state;
  coord_t     cx, cy;
  logic       disparo_q, invalido_q, activo_q;
  logic       turno_ok;
  celda_t     celda;
  logic       expira;

  assign turno_ok = bus.turno && (bus.estado == EST_JUGADOR);
  assign celda    = bus.pc_board[cy][cx];

`ifdef TURNO_TIMEOUT_EN
  localparam logic [31:0] LIMITE = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] cnt;
  celda_sel_t  libre;

  assign expira = (cnt == LIMITE);

  // Scan backwards so the last hit written is the first unshot cell in
  // raster order (row y first, then column x).
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    libre = '0;
    for (int fy = N - 1; fy >= 0; fy--) begin
      for (int fx = N - 1; fx >= 0; fx--) begin
        if (!celda_disparada(bus.pc_board[fy][fx])) begin
          libre.hit = 1'b1;
          libre.x   = coord_t'(fx);
          libre.y   = coord_t'(fy);
        end
      end
    end
  end
`else
  assign expira = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      disparo_q  <= 1'b0;
      invalido_q <= 1'b0;
      activo_q   <= 1'b0;
`ifdef TURNO_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      disparo_q  <= 1'b0;
      invalido_q <= 1'b0;

      case (state)
        IDLE: begin
          if (turno_ok) begin
            state    <= SELECT;
            activo_q <= 1'b1;
`ifdef TURNO_TIMEOUT_EN
            cnt      <= '0;
`endif
          end
        end

        SELECT: begin
`ifdef TURNO_TIMEOUT_EN
          cnt <= cnt + 32'd1;
`endif
          // Turn loss outranks everything, including a confirm in the same cycle.
          if (!turno_ok) begin
            state    <= IDLE;
            activo_q <= 1'b0;
          end else if (expira) begin
`ifdef TURNO_TIMEOUT_EN
            activo_q <= 1'b0;
            if (libre.hit) begin
              cx        <= libre.x;
              cy        <= libre.y;
              disparo_q <= 1'b1;
              state     <= FIRE;
            end else begin
              state <= IDLE;
            end
`endif
          end else if (flanco[BTN_DISPARO]) begin
            if (celda_disparada(celda)) begin
              invalido_q <= 1'b1;
            end else begin
              disparo_q <= 1'b1;
              activo_q  <= 1'b0;
              state     <= FIRE;
            end
          end else if (flanco[BTN_ARRIBA]) begin
            cy <= (cy == '0) ? MAX_C : cy - 3'd1;
          end else if (flanco[BTN_ABAJO]) begin
            cy <= (cy == MAX_C) ? '0 : cy + 3'd1;
          end else if (flanco[BTN_IZQ]) begin
            cx <= (cx == '0) ? MAX_C : cx - 3'd1;
          end else if (flanco[BTN_DER]) begin
            cx <= (cx == MAX_C) ? '0 : cx + 3'd1;
          end
        end

        FIRE: state <= WAIT;

        // Holding here until the turn ends is what limits play to one shot per turn.
        WAIT: begin
          if (!turno_ok) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x        = cx;
  assign bus.y        = cy;
  assign bus.disparo  = disparo_q;
  assign bus.invalido = invalido_q;
  assign bus.activo   = activo_q;

endmodule

// File: tb/tb_selector_disparo.sv
// Directed self-checking bench for selector_disparo: reset, cursor wrap,
// button priority, fire/invalid/turn-loss handling, timeout and mid-run reset.
module tb_selector_disparo;
  import juego_pkg::*;

  localparam logic [4:0] B_DER  = 5'b00001;
  localparam logic [4:0] B_IZQ  = 5'b00010;
  localparam logic [4:0] B_ABA  = 5'b00100;
  localparam logic [4:0] B_ARR  = 5'b01000;
  localparam logic [4:0] B_DISP = 5'b10000;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  selector_disparo_if #(.N(N_TABLERO)) bus ();

  selector_disparo #(
    .N              (N_TABLERO),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the buttons in mask m for exactly one cycle, then release them.
  task automatic press(input logic [4:0] m);
    {bus.btn_disparo, bus.btn_arriba, bus.btn_abajo, bus.btn_izq, bus.btn_der} = m;
    @(negedge clk);
    {bus.btn_disparo, bus.btn_arriba, bus.btn_abajo, bus.btn_izq, bus.btn_der} = '0;
  endtask

  task automatic clear_board();
    for (int r = 0; r < N_TABLERO; r++)
      for (int c = 0; c < N_TABLERO; c++)
        bus.pc_board[r][c] = CELDA_AGUA;
  endtask

  initial begin
    reset = 1'b0;
    bus.turno  = 1'b1;
    bus.estado = EST_JUGADOR;
    {bus.btn_disparo, bus.btn_arriba, bus.btn_abajo, bus.btn_izq, bus.btn_der} = '0;
    bus.btn_der = 1'b1;
    clear_board();

    // 1. reset with der held
    idle(2);
    check("rst_x", 32'(bus.x), 0);
    check("rst_y", 32'(bus.y), 0);
    check("rst_disparo", 32'(bus.disparo), 0);
    check("rst_invalido", 32'(bus.invalido), 0);
    check("rst_activo", 32'(bus.activo), 0);
    reset = 1'b1;
    idle(1);
    check("enter_select_activo", 32'(bus.activo), 1);
    idle(1);
    check("held_der_no_move", 32'(bus.x), 0);
    bus.btn_der = 1'b0;
    idle(1);

    // 2. moves and wrap-around
    repeat (4) begin
      press(B_DER);
      idle(1);
    end
    check("der_x4", 32'(bus.x), 4);
    press(B_DER);
    check("der_wrap_x0", 32'(bus.x), 0);
    idle(1);
    press(B_ARR);
    check("arr_wrap_y4", 32'(bus.y), 4);
    idle(1);
    press(B_ABA);
    check("aba_wrap_y0", 32'(bus.y), 0);
    idle(1);
    press(B_IZQ);
    check("izq_wrap_x4", 32'(bus.x), 4);
    idle(1);
    press(B_DER);
    check("der_wrap_back_x0", 32'(bus.x), 0);
    idle(1);
    press(B_ARR | B_DER);
    check("prio_arr_y", 32'(bus.y), 4);
    check("prio_arr_x_dropped", 32'(bus.x), 0);
    idle(1);
    press(B_ABA | B_IZQ);
    check("prio_aba_y", 32'(bus.y), 0);
    check("prio_aba_x_dropped", 32'(bus.x), 0);
    idle(1);

    // 3. valid shot, one per turn
    bus.pc_board[0][0] = CELDA_BARCO;
    press(B_DISP);
    check("fire_disparo", 32'(bus.disparo), 1);
    check("fire_x", 32'(bus.x), 0);
    check("fire_y", 32'(bus.y), 0);
    check("fire_activo", 32'(bus.activo), 0);
    idle(1);
    check("fire_one_cycle", 32'(bus.disparo), 0);
    press(B_DISP);
    check("wait_no_second_shot", 32'(bus.disparo), 0);
    idle(1);
    check("wait_no_second_shot_2", 32'(bus.disparo), 0);
    press(B_DER);
    check("wait_ignores_move", 32'(bus.x), 0);
    idle(1);
    bus.turno = 1'b0;
    idle(1);
    check("turn_end_idle", 32'(bus.activo), 0);
    press(B_DER);
    check("idle_ignores_move", 32'(bus.x), 0);
    idle(1);
    bus.turno = 1'b1;
    idle(1);
    check("new_turn_select", 32'(bus.activo), 1);

    // 4. invalid confirms on shot cells
    bus.pc_board[2][3] = CELDA_FALLADO;
    bus.pc_board[2][4] = CELDA_TOCADO;
    repeat (3) begin
      press(B_DER);
      idle(1);
    end
    repeat (2) begin
      press(B_ABA);
      idle(1);
    end
    check("cursor_x3", 32'(bus.x), 3);
    check("cursor_y2", 32'(bus.y), 2);
    press(B_DISP);
    check("fallado_invalido", 32'(bus.invalido), 1);
    check("fallado_no_disparo", 32'(bus.disparo), 0);
    check("fallado_stay_select", 32'(bus.activo), 1);
    idle(1);
    check("invalido_one_cycle", 32'(bus.invalido), 0);
    press(B_DER);
    idle(1);
    press(B_DISP);
    check("tocado_invalido", 32'(bus.invalido), 1);
    check("tocado_no_disparo", 32'(bus.disparo), 0);
    idle(1);

    // 5. turn loss together with confirm on a valid cell
    repeat (2) begin
      press(B_IZQ);
      idle(1);
    end
    bus.turno = 1'b0;
    press(B_DISP);
    check("loss_no_disparo", 32'(bus.disparo), 0);
    check("loss_no_invalido", 32'(bus.invalido), 0);
    check("loss_activo", 32'(bus.activo), 0);
    idle(1);
    check("loss_no_late_disparo", 32'(bus.disparo), 0);
    check("hold_x", 32'(bus.x), 2);
    check("hold_y", 32'(bus.y), 2);

    // 6. timeout (or indefinite wait when the feature is absent)
    clear_board();
    for (int c = 0; c < N_TABLERO; c++) bus.pc_board[0][c] = CELDA_TOCADO;
    bus.turno = 1'b1;
    idle(1);
    check("to_select", 32'(bus.activo), 1);
`ifdef TURNO_TIMEOUT_EN
    idle(19);
    check("to_not_yet", 32'(bus.disparo), 0);
    check("to_not_yet_activo", 32'(bus.activo), 1);
    idle(1);
    check("to_disparo", 32'(bus.disparo), 1);
    check("to_x", 32'(bus.x), 0);
    check("to_y", 32'(bus.y), 1);
    idle(1);
    check("to_one_cycle", 32'(bus.disparo), 0);
`else
    idle(40);
    check("no_to_activo", 32'(bus.activo), 1);
    check("no_to_disparo", 32'(bus.disparo), 0);
    check("no_to_x", 32'(bus.x), 2);
`endif

    // 7. reset mid-operation with a confirm pending, button held through it
    bus.btn_disparo = 1'b1;
    reset = 1'b0;
    idle(1);
    check("midrst_disparo", 32'(bus.disparo), 0);
    check("midrst_activo", 32'(bus.activo), 0);
    check("midrst_x", 32'(bus.x), 0);
    check("midrst_y", 32'(bus.y), 0);
    reset = 1'b1;
    idle(1);
    check("midrst_reselect", 32'(bus.activo), 1);
    idle(1);
    check("held_disp_no_fire", 32'(bus.disparo), 0);
    check("held_disp_still_select", 32'(bus.activo), 1);
    bus.btn_disparo = 1'b0;
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
